// File: rtl/pipe_ctrl_if.sv
// Data-memory handshake between the pipeline sequencer (master) and the data memory (slave).
interface pipe_ctrl_if;
    logic mem_req;
    logic mem_ack;

    modport master (output mem_req, input mem_ack);
    modport slave  (input mem_req, output mem_ack);
endinterface

// File: rtl/pipe_ctrl.sv
// Three-stage (IF/ID/IE) pipeline sequencer: stage enables, valid tags, load-use bubbles,
// predictor squashes, halt and the data-memory handshake with timeout.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [1:0]  flash,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic [2:0]  ie_rd,
    input  logic        ie_is_load,
    input  logic        ie_mem,
    input  logic        ie_halt,
    pipe_ctrl_if.master mem,
    output logic        pc_en,
    output logic        if_en,
    output logic        id_en,
    output logic        ie_en,
    output logic        if_valid,
    output logic        id_valid,
    output logic        ie_valid,
    output logic        wb_en,
    output logic [1:0]  state,
    output logic        err,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_MEMWAIT = 2'b10,
        S_HALT    = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic       if_valid_d, id_valid_d, ie_valid_d;
    logic       err_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       stall_inc;
    logic       advance;

    logic mreq;
    logic lu;
    logic flush;

    assign mreq  = ie_valid & ie_mem;
    assign lu    = ie_valid & ie_is_load & id_valid & (ie_rd != 3'd0) &
                   ((id_rs == ie_rd) | (id_rt == ie_rd));
    assign flush = (flash == 2'b01) | (flash == 2'b10);
    assign state = state_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        if_valid_d  = if_valid;
        id_valid_d  = id_valid;
        ie_valid_d  = ie_valid;
        err_d       = err;
        tcnt_d      = tcnt_q;
        stall_inc   = 1'b0;
        advance     = 1'b0;
        pc_en       = 1'b0;
        if_en       = 1'b0;
        id_en       = 1'b0;
        ie_en       = 1'b0;
        wb_en       = 1'b0;
        mem.mem_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_RUN;
                    if_valid_d = 1'b0;
                    id_valid_d = 1'b0;
                    ie_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                mem.mem_req = mreq;
                if (mreq && !mem.mem_ack) begin
                    state_d   = S_MEMWAIT;
                    tcnt_d    = 8'd1;
                    stall_inc = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_MEMWAIT: begin
                mem.mem_req = 1'b1;
                // The ack cycle lets the pipeline move, so only the frozen cycles count as stalls.
                if (mem.mem_ack) begin
                    advance = 1'b1;
                end else if (tcnt_q == 8'(MEM_TIMEOUT)) begin
                    state_d    = S_HALT;
                    err_d      = 1'b1;
                    if_valid_d = 1'b0;
                    id_valid_d = 1'b0;
                    ie_valid_d = 1'b0;
                    stall_inc  = 1'b1;
                end else begin
                    tcnt_d    = tcnt_q + 8'd1;
                    stall_inc = 1'b1;
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (advance) begin
            state_d = S_RUN;
            if (flush) begin
                // A predictor squash outranks the load-use hazard: the squashed slots carry nothing to stall for.
                pc_en      = 1'b1;
                if_en      = 1'b1;
                id_en      = 1'b1;
                ie_en      = 1'b1;
                if_valid_d = 1'b1;
                id_valid_d = 1'b0;
                ie_valid_d = (flash == 2'b01) ? id_valid : 1'b0;
            end else if (lu) begin
                ie_en      = 1'b1;
                ie_valid_d = 1'b0;
                stall_inc  = 1'b1;
            end else begin
                pc_en      = 1'b1;
                if_en      = 1'b1;
                id_en      = 1'b1;
                ie_en      = 1'b1;
                if_valid_d = 1'b1;
                id_valid_d = if_valid;
                ie_valid_d = id_valid;
            end

            wb_en = ie_valid & ie_en;
            if (wb_en && ie_halt) begin
                state_d    = S_HALT;
                if_valid_d = 1'b0;
                id_valid_d = 1'b0;
                ie_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            if_valid  <= 1'b0;
            id_valid  <= 1'b0;
            ie_valid  <= 1'b0;
            err       <= 1'b0;
            tcnt_q    <= 8'd0;
            stall_cnt <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q  <= state_d;
            if_valid <= if_valid_d;
            id_valid <= id_valid_d;
            ie_valid <= ie_valid_d;
            err      <= err_d;
            tcnt_q   <= tcnt_d;
            if (stall_inc && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected outputs,
// a monitor pops them and compares combinational outputs mid-cycle and registers after the edge.
module tb_pipe_ctrl;

    logic       clock;
    logic       reset;
    logic       run;
    logic [1:0] flash;
    logic [2:0] id_rs, id_rt, ie_rd;
    logic       ie_is_load, ie_mem, ie_halt;
    logic       pc_en, if_en, id_en, ie_en;
    logic       if_valid, id_valid, ie_valid;
    logic       wb_en;
    logic [1:0] state;
    logic       err;
    logic [7:0] stall_cnt;

    pipe_ctrl_if mem_if();

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .flash      (flash),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ie_rd      (ie_rd),
        .ie_is_load (ie_is_load),
        .ie_mem     (ie_mem),
        .ie_halt    (ie_halt),
        .mem        (mem_if),
        .pc_en      (pc_en),
        .if_en      (if_en),
        .id_en      (id_en),
        .ie_en      (ie_en),
        .if_valid   (if_valid),
        .id_valid   (id_valid),
        .ie_valid   (ie_valid),
        .wb_en      (wb_en),
        .state      (state),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        string      tag;
        logic [5:0] comb;  // {pc_en, if_en, id_en, ie_en, mem_req, wb_en}
        logic [1:0] st;
        logic [2:0] v;     // {if_valid, id_valid, ie_valid}
        logic       err;
        logic [7:0] sc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            cur = sb[0];
            check({cur.tag, ".comb"},
                  32'({pc_en, if_en, id_en, ie_en, mem_if.mem_req, wb_en}), 32'(cur.comb));
            @(posedge clock);
            #1;
            check({cur.tag, ".state"}, 32'(state), 32'(cur.st));
            check({cur.tag, ".valid"}, 32'({if_valid, id_valid, ie_valid}), 32'(cur.v));
            check({cur.tag, ".err"}, 32'(err), 32'(cur.err));
            check({cur.tag, ".stall"}, 32'(stall_cnt), 32'(cur.sc));
            sb.delete(0);
        end
    end

    // Called at 2 time units after a rising edge; returns at the same point one cycle later.
    task automatic step(input string tag, input logic r, input logic [1:0] fl, input logic ld,
                        input logic mm, input logic ak, input logic hl,
                        input logic [5:0] c, input logic [1:0] s, input logic [2:0] v,
                        input logic e, input logic [7:0] sc);
        exp_t x;
        run             = r;
        flash           = fl;
        ie_is_load      = ld;
        ie_mem          = mm;
        mem_if.mem_ack  = ak;
        ie_halt         = hl;
        x.tag  = tag;
        x.comb = c;
        x.st   = s;
        x.v    = v;
        x.err  = e;
        x.sc   = sc;
        sb.push_back(x);
        @(posedge clock);
        #2;
    endtask

    task automatic regs(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        id_rs = rs;
        id_rt = rt;
        ie_rd = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run = 1'b0;
        flash = 2'b00;
        ie_is_load = 1'b0;
        ie_mem = 1'b0;
        ie_halt = 1'b0;
        mem_if.mem_ack = 1'b0;
        regs(3'd1, 3'd2, 3'd4);
        #1 reset = 1'b0;
        #2;
        check("rst.state", 32'(state), 32'd0);
        check("rst.valid", 32'({if_valid, id_valid, ie_valid}), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.stall", 32'(stall_cnt), 32'd0);
        check("rst.comb", 32'({pc_en, if_en, id_en, ie_en, mem_if.mem_req, wb_en}), 32'd0);
        #9 reset = 1'b1;
        @(posedge clock);
        #2;

        // Start and hazard-free flow
        step("idle",    0, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 3'b000, 0, 8'd0);
        step("start",   1, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b01, 3'b000, 0, 8'd0);
        step("fill1",   1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b100, 0, 8'd0);
        step("fill2",   1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b110, 0, 8'd0);
        step("fill3",   1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd0);
        step("flow1",   1, 2'b00, 0, 0, 0, 0, 6'b111101, 2'b01, 3'b111, 0, 8'd0);
        step("flow2",   1, 2'b00, 0, 0, 0, 0, 6'b111101, 2'b01, 3'b111, 0, 8'd0);

        // Load-use on rs, then ie_rd=0 never stalls
        regs(3'd3, 3'd5, 3'd3);
        step("lu_rs",   1, 2'b00, 1, 0, 0, 0, 6'b000101, 2'b01, 3'b110, 0, 8'd1);
        step("lu_next", 1, 2'b00, 1, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd1);
        regs(3'd0, 3'd5, 3'd0);
        step("lu_rd0",  1, 2'b00, 1, 0, 0, 0, 6'b111101, 2'b01, 3'b111, 0, 8'd1);

        // Squash two stages over a load-use hazard, then squash one
        regs(3'd3, 3'd5, 3'd3);
        step("fl10",    1, 2'b10, 1, 0, 0, 0, 6'b111101, 2'b01, 3'b100, 0, 8'd1);
        regs(3'd1, 3'd2, 3'd4);
        step("fl10_a",  1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b110, 0, 8'd1);
        step("fl10_b",  1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd1);
        step("fl01",    1, 2'b01, 0, 0, 0, 0, 6'b111101, 2'b01, 3'b101, 0, 8'd1);
        step("fl01_a",  1, 2'b00, 0, 0, 0, 0, 6'b111101, 2'b01, 3'b110, 0, 8'd1);
        step("fl01_b",  1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd1);

        // Load-use on rt
        regs(3'd1, 3'd6, 3'd6);
        step("lu_rt",   1, 2'b00, 1, 0, 0, 0, 6'b000101, 2'b01, 3'b110, 0, 8'd2);
        regs(3'd1, 3'd2, 3'd4);
        step("lu_rt_a", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd2);

        // Memory ack three cycles late, then a single-cycle access
        step("mw_req",  1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd3);
        step("mw_w1",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd4);
        step("mw_w2",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd5);
        step("mw_ack",  1, 2'b00, 0, 1, 1, 0, 6'b111111, 2'b01, 3'b111, 0, 8'd5);
        step("mem_1cy", 1, 2'b00, 0, 1, 1, 0, 6'b111111, 2'b01, 3'b111, 0, 8'd5);

        // Ack arriving together with a squash
        step("mw2_req", 1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd6);
        step("mw2_fl",  1, 2'b10, 0, 1, 1, 0, 6'b111111, 2'b01, 3'b100, 0, 8'd6);
        step("mw2_a",   1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b110, 0, 8'd6);
        step("mw2_b",   1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd6);

        // Timeout after four MEMWAIT cycles
        step("to_req",  1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd7);
        step("to_w1",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd8);
        step("to_w2",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd9);
        step("to_w3",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd10);
        step("to_w4",   1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b11, 3'b000, 1, 8'd11);
        step("to_hold", 1, 2'b00, 0, 1, 0, 0, 6'b000000, 2'b11, 3'b000, 1, 8'd11);
        step("to_stop", 0, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 3'b000, 1, 8'd11);
        step("to_idle", 0, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 3'b000, 1, 8'd11);

        // Asynchronous reset between edges clears err at once
        #2 reset = 1'b0;
        #1;
        check("arst.err", 32'(err), 32'd0);
        check("arst.state", 32'(state), 32'd0);
        check("arst.stall", 32'(stall_cnt), 32'd0);
        #3 reset = 1'b1;
        @(posedge clock);
        #2;

        // Halt commits despite a squash
        step("h_start", 1, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b01, 3'b000, 0, 8'd0);
        step("h_fill1", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b100, 0, 8'd0);
        step("h_fill2", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b110, 0, 8'd0);
        step("h_fill3", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd0);
        step("halt",    1, 2'b01, 0, 0, 0, 1, 6'b111101, 2'b11, 3'b000, 0, 8'd0);
        step("halted",  1, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b11, 3'b000, 0, 8'd0);
        step("h_idle",  0, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 3'b000, 0, 8'd0);

        // Reset in the middle of a memory wait
        step("r_start", 1, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b01, 3'b000, 0, 8'd0);
        step("r_fill1", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b100, 0, 8'd0);
        step("r_fill2", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b110, 0, 8'd0);
        step("r_fill3", 1, 2'b00, 0, 0, 0, 0, 6'b111100, 2'b01, 3'b111, 0, 8'd0);
        step("r_mwreq", 1, 2'b00, 0, 1, 0, 0, 6'b000010, 2'b10, 3'b111, 0, 8'd1);
        #2;
        check("mwrst.req_before", 32'(mem_if.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("mwrst.req", 32'(mem_if.mem_req), 32'd0);
        check("mwrst.state", 32'(state), 32'd0);
        check("mwrst.en", 32'({pc_en, if_en, id_en, ie_en, wb_en}), 32'd0);
        check("mwrst.valid", 32'({if_valid, id_valid, ie_valid}), 32'd0);
        run = 1'b0;
        ie_mem = 1'b0;
        #3 reset = 1'b1;
        @(posedge clock);
        #2;
        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
